// File: rtl/quant_pkg.sv
// Shared definitions for the activation quantizer / dequantizer pair:
// default datapath widths, FSM state encoding and a counter-width helper.
package quant_pkg;

  // Default widths shared by the quantizer stages.
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_IDX_W  = 8;

  // Handshaked iterative-unit states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width: enough to index IDX_W positions, never zero width.
  function automatic int cnt_w(input int idx_w);
    return (idx_w <= 1) ? 1 : $clog2(idx_w);
  endfunction

endpackage

// File: rtl/dequant_shift_add.sv
// One shift-add multiplier step: adds unit<<cnt to the accumulator when the
// current index bit is set. Purely combinational; the caller owns all state.
module dequant_shift_add
  import quant_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 3
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] unit_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] partial;

  // Partial product for this bit position; plain DATA_W-bit add, no carry out
  // is needed because index*unit never exceeds the tensor maximum.
  always_comb begin
    partial = bit_i ? (unit_i << cnt_i) : '0;
    acc_o   = acc_i + partial;
  end

endmodule

// File: rtl/dequantizer.sv
// Dequantizer: rebuilds a DATA_W-bit activation from an IDX_W-bit index as
// index * (i_max >> IDX_W), one index bit per BUSY cycle.
// Build option: DEQUANT_ROUND_EN adds unit>>1 (bin midpoint) in the DONE load.
module dequantizer
  import quant_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IDX_W  = DEFAULT_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_max,
  input  logic [IDX_W-1:0]  i_index,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_activation
);

  localparam int              CNT_W = cnt_w(IDX_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IDX_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] unit_q;
  logic [IDX_W-1:0]  shreg_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] act_q;

  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] result_d;

  dequant_shift_add #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_step (
    .acc_i  (acc_q),
    .unit_i (unit_q),
    .cnt_i  (cnt_q),
    .bit_i  (shreg_q[0]),
    .acc_o  (acc_d)
  );

  // Value loaded into o_activation on the last BUSY edge; the midpoint offset
  // is folded in here so both builds share the same latency.
  always_comb begin
`ifdef DEQUANT_ROUND_EN
    result_d = acc_d + (unit_q >> 1);
`else
    result_d = acc_d;
`endif
  end

  // Handshake FSM plus the iterative multiplier datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      unit_q  <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            unit_q  <= i_max >> IDX_W;
            shreg_q <= i_index;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_q >> 1;
          if (cnt_q == LAST) begin
            // Final bit consumed: publish the sum and park the counter.
            act_q   <= result_d;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Result and valid hold until the consumer takes them.
          if (i_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready      = (state_q == IDLE);
  assign o_valid      = (state_q == DONE);
  assign o_activation = act_q;

endmodule
